result_queue_drain: RTL and testbench
=====================================

RESULT_QUEUE_DRAIN -- requirements
Module: result_queue_drain

Interface
REQ-001 Parameter OUT_COORD_BITS, default 16: width of rescaled output coordinates.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of the scale-factor table entries.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rq_q  in  pkg_resultQueue::WIDTH  queue head packed {scale, y, x}, x in LSBs (intf_resultQueue_Read.q).
REQ-006 rq_empty  in  1  queue empty (intf_resultQueue_Read.empty).
REQ-007 rq_re  out  1  one-cycle pop strobe (intf_resultQueue_Read.re).
REQ-008 frame_done  in  1  one-cycle pulse: detector finished the frame.
REQ-009 out_valid  out  1  output record valid.
REQ-010 out_ready  in  1  consumer accepts the record when out_valid&&out_ready.
REQ-011 out_x, out_y  out  OUT_COORD_BITS each  coordinates in original-image space.
REQ-012 out_scale  out  resultQueueScaleBits  scale iteration of the record.
REQ-013 out_eof  out  1  record is an end-of-frame marker.
REQ-014 det_count  out  16  detections in the frame; meaningful only with out_eof.

Function
REQ-015 FSM states: IDLE, POP, CAPTURE, SCALE, EMIT, EOF.
REQ-016 IDLE->POP when !rq_empty; otherwise IDLE->EOF when eof_pending && rq_empty; otherwise stay in IDLE.
REQ-017 POP: rq_re=1 for exactly one cycle, then CAPTURE; rq_re=0 in every other state.
REQ-018 CAPTURE: latch rq_q (queue read latency is one cycle), then SCALE.
REQ-019 SCALE: f = scaleFactorTable[scale]; out_x = (x*f)>>FRAC_BITS and out_y = (y*f)>>FRAC_BITS, truncated and then saturated to all-ones of OUT_COORD_BITS; registered; then EMIT.
REQ-020 A scale index >= supportedScaleIterations uses factor 1.0 (1<<FRAC_BITS).
REQ-021 EMIT: out_valid=1, out_eof=0; fields held stable until out_ready; on handshake go to IDLE.
REQ-022 out_valid rises exactly 3 cycles after the rq_re cycle; minimum record spacing is 5 cycles.
REQ-023 No pop occurs while a record is pending; backpressure never drops or reorders entries.
REQ-024 frame_done sets eof_pending in any state; a pulse arriving while eof_pending is already set is absorbed.
REQ-025 EOF state: out_valid=1, out_eof=1, out_x=out_y=out_scale=0, det_count as per REQ-031; on handshake clear eof_pending, return to IDLE.
REQ-026 The EOF record is emitted only after the queue is empty and the current record has been accepted, so every detection precedes its frame's EOF.
REQ-027 If frame_done and rq_empty fall in the same IDLE cycle, the queued entry is drained first.

Reset
REQ-028 While reset is asserted: state=IDLE; rq_re, out_valid, out_eof=0; out_x, out_y, out_scale, det_count=0; eof_pending=0.
REQ-029 Reset mid-record discards the captured entry with no output; a popped entry is lost, which is acceptable.
REQ-030 First pop possible 2 cycles after reset deassertion (IDLE sample, then POP).

Configuration
REQ-031 RESULT_QUEUE_DRAIN_STATS_EN defined: a 16-bit counter increments on each EMIT handshake, saturates at 0xFFFF, drives det_count on EOF, and clears on the EOF handshake.
REQ-032 RESULT_QUEUE_DRAIN_STATS_EN undefined: no counter is built and det_count is constant 0; all other behaviour is identical.

Structure
REQ-033 New package pkg_resultDrain (imports pkg_resultQueue, globalDefinitions) holds: FSM state enum, OUT_COORD_BITS/FRAC_BITS defaults, and scaleFactorTable[supportedScaleIterations] of unsigned 16-bit Q8.8 entries, entry s = round(1.25^s * 256).
REQ-034 One sub-module, result_drain_scaler: table lookup plus two multiplies with saturation, purely combinational, registered by the parent in SCALE.
REQ-035 Queue ports connect through intf_resultQueue_Read; no change to pkg_resultQueue.

Verification
REQ-036 Entry {s=0, y=20, x=10}, out_ready=1 -> out_x=10, out_y=20, out_scale=0; out_valid exactly 3 cycles after rq_re.
REQ-037 Entry {s=2, y=7, x=100}, f=400 -> out_x=156, out_y=10.
REQ-038 out_ready=0 for 5 cycles with 2 entries queued -> record held stable, no rq_re during the stall; both records delivered in order after out_ready=1.
REQ-039 3 entries queued, frame_done pulsed during the first EMIT -> 3 records, then EOF with det_count=3 (0 without the macro); a second frame -> det_count restarts at 1 for a 1-entry frame.
REQ-040 Reset asserted during EMIT -> out_valid=0 immediately; after release, next queued entry processed normally; no spurious EOF.
REQ-041 frame_done with queue empty -> EOF record with det_count=0 within 2 cycles of the pulse.

Source files
------------

// File: rtl/result_queue_drain_pkg.sv
// result_queue_drain_pkg: shared queue/global definitions plus drain FSM states and Q8.8 scale-factor table
package globalDefinitions;
  localparam int supportedScaleIterations = 8;
endpackage

package pkg_resultQueue;
  localparam int resultQueueScaleBits = 4;
  localparam int resultQueueCoordBits = 16;
  localparam int WIDTH = resultQueueScaleBits + 2 * resultQueueCoordBits;
endpackage

package pkg_resultDrain;
  import pkg_resultQueue::*;
  import globalDefinitions::*;
  typedef enum logic [2:0] {IDLE, POP, CAPTURE, SCALE, EMIT, EOF} drain_state_t;
  localparam int DEFAULT_OUT_COORD_BITS = 16;
  localparam int DEFAULT_FRAC_BITS = 8;
  localparam int SCALE_IDX_BITS = $clog2(supportedScaleIterations);
  // round(1.25^s * 256)
  localparam logic [15:0] scaleFactorTable [supportedScaleIterations] =
    '{16'd256, 16'd320, 16'd400, 16'd500, 16'd625, 16'd781, 16'd977, 16'd1221};
endpackage

// File: rtl/result_drain_scaler.sv
// result_drain_scaler: combinational scale-factor lookup and saturating coordinate rescale
module result_drain_scaler
  import pkg_resultQueue::*, globalDefinitions::*, pkg_resultDrain::*;
#(
  parameter int OUT_COORD_BITS = DEFAULT_OUT_COORD_BITS,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic [resultQueueCoordBits-1:0] x,
  input  logic [resultQueueCoordBits-1:0] y,
  input  logic [resultQueueScaleBits-1:0] scale,
  output logic [OUT_COORD_BITS-1:0]       sx,
  output logic [OUT_COORD_BITS-1:0]       sy
);
  localparam int PW = resultQueueCoordBits + 16;
  logic [15:0] f;
  logic [PW-1:0] px, py;
  always_comb begin
    f = 32'(scale) < supportedScaleIterations ? scaleFactorTable[scale[SCALE_IDX_BITS-1:0]] : 16'(1 << FRAC_BITS);
    px = (PW'(x) * PW'(f)) >> FRAC_BITS;
    py = (PW'(y) * PW'(f)) >> FRAC_BITS;
    sx = |px[PW-1:OUT_COORD_BITS] ? '1 : px[OUT_COORD_BITS-1:0];
    sy = |py[PW-1:OUT_COORD_BITS] ? '1 : py[OUT_COORD_BITS-1:0];
  end
endmodule

// File: rtl/result_queue_drain.sv
// result_queue_drain: pops detections, rescales them to image space, appends an EOF record per frame.
// Optional per-frame detection counter on det_count: RESULT_QUEUE_DRAIN_STATS_EN.
module result_queue_drain
  import pkg_resultQueue::*, pkg_resultDrain::*;
#(
  parameter int OUT_COORD_BITS = DEFAULT_OUT_COORD_BITS,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                rq_q,
  input  logic                            rq_empty,
  output logic                            rq_re,
  input  logic                            frame_done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_COORD_BITS-1:0]       out_x,
  output logic [OUT_COORD_BITS-1:0]       out_y,
  output logic [resultQueueScaleBits-1:0] out_scale,
  output logic                            out_eof,
  output logic [15:0]                     det_count
);
  localparam int CB = resultQueueCoordBits;
  drain_state_t state, nxt;
  logic [WIDTH-1:0] cap;
  logic [OUT_COORD_BITS-1:0] sx, sy, x_r, y_r;
  logic [resultQueueScaleBits-1:0] s_r;
  logic eof_pending;

  result_drain_scaler #(.OUT_COORD_BITS(OUT_COORD_BITS), .FRAC_BITS(FRAC_BITS)) u_scaler (
    .x(cap[CB-1:0]),
    .y(cap[2*CB-1:CB]),
    .scale(cap[WIDTH-1:2*CB]),
    .sx(sx),
    .sy(sy)
  );

  // queued entries always win over a pending EOF so detections precede their frame marker
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = !rq_empty ? POP : eof_pending ? EOF : IDLE;
      POP:       nxt = CAPTURE;
      CAPTURE:   nxt = SCALE;
      SCALE:     nxt = EMIT;
      EMIT, EOF: nxt = out_ready ? IDLE : state;
      default:   nxt = IDLE;
    endcase
  end

  assign rq_re     = state == POP;
  assign out_eof   = state == EOF;
  assign out_valid = state == EMIT || state == EOF;
  assign out_x     = out_eof ? '0 : x_r;
  assign out_y     = out_eof ? '0 : y_r;
  assign out_scale = out_eof ? '0 : s_r;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cap <= '0;
      x_r <= '0;
      y_r <= '0;
      s_r <= '0;
      eof_pending <= 1'b0;
    end else begin
      state <= nxt;
      eof_pending <= (state == EOF && out_ready) ? 1'b0 : eof_pending | frame_done;
      if (state == CAPTURE) cap <= rq_q;
      if (state == SCALE) begin
        x_r <= sx;
        y_r <= sy;
        s_r <= cap[WIDTH-1:2*CB];
      end
    end

`ifdef RESULT_QUEUE_DRAIN_STATS_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (state == EOF && out_ready) cnt <= '0;
    else if (state == EMIT && out_ready && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign det_count = out_eof ? cnt : '0;
`else
  assign det_count = '0;
`endif
endmodule

// File: tb/tb_result_queue_drain.sv
// tb_result_queue_drain: scoreboard bench with a one-cycle-latency queue model feeding result_queue_drain
module tb_result_queue_drain;
  import pkg_resultQueue::*;
  typedef struct packed {
    logic        eof;
    logic [15:0] cnt;
    logic [3:0]  s;
    logic [15:0] y;
    logic [15:0] x;
  } rec_t;
`ifdef RESULT_QUEUE_DRAIN_STATS_EN
  localparam logic [15:0] CNT3 = 16'd3;
  localparam logic [15:0] CNT1 = 16'd1;
`else
  localparam logic [15:0] CNT3 = 16'd0;
  localparam logic [15:0] CNT1 = 16'd0;
`endif
  logic clk = 0, reset = 0, frame_done = 0, out_ready = 0;
  logic rq_empty, rq_re, out_valid, out_eof;
  logic [WIDTH-1:0] rq_q = '0;
  logic [15:0] out_x, out_y, det_count;
  logic [3:0] out_scale;
  logic [WIDTH-1:0] mem [64];
  rec_t exp_mem [64];
  int wp = 0, rp = 0, ewp = 0, erp = 0, cyc = 0, total = 0, bad = 0;

  result_queue_drain dut (
    .clk(clk), .reset(reset), .rq_q(rq_q), .rq_empty(rq_empty), .rq_re(rq_re),
    .frame_done(frame_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_scale(out_scale), .out_eof(out_eof),
    .det_count(det_count)
  );

  always #5 clk = ~clk;
  assign rq_empty = (wp == rp);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rq_re) begin
      rq_q <= mem[rp];
      rp <= rp + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [15:0] y, input logic [15:0] x,
                      input logic [15:0] ex, input logic [15:0] ey, input bit e);
    mem[wp] = {s, y, x};
    wp++;
    if (e) begin
      exp_mem[ewp] = '{eof: 1'b0, cnt: 16'd0, s: s, y: ey, x: ex};
      ewp++;
    end
  endtask

  task automatic push_eof(input logic [15:0] c);
    exp_mem[ewp] = '{eof: 1'b1, cnt: c, s: 4'd0, y: 16'd0, x: 16'd0};
    ewp++;
  endtask

  task automatic monitor;
    rec_t act;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        act = '{eof: out_eof, cnt: out_eof ? det_count : 16'd0, s: out_scale, y: out_y, x: out_x};
        if (erp == ewp) begin
          total++;
          bad++;
          $display("FAIL unexpected_record got=%h want=none", act);
        end else begin
          check($sformatf("record%0d", erp), 64'(act), 64'(exp_mem[erp]));
          erp++;
        end
      end
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    check(name, 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && erp != ewp; i++) @(negedge clk);
    check(name, 64'(erp), 64'(ewp));
  endtask

  initial begin
    int t0;
    bit found;
    fork monitor(); join_none
    reset = 1;
    repeat (2) step;
    check("rst_rq_re", 64'(rq_re), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_eof", 64'(out_eof), 64'd0);
    check("rst_x", 64'(out_x), 64'd0);
    check("rst_y", 64'(out_y), 64'd0);
    check("rst_scale", 64'(out_scale), 64'd0);
    check("rst_count", 64'(det_count), 64'd0);
    reset = 0;
    out_ready = 1;
    step;
    // frame_done with empty queue: EOF within 2 cycles
    frame_done = 1;
    push_eof(16'd0);
    step;
    frame_done = 0;
    found = 0;
    for (int i = 0; i < 2 && !found; i++) begin
      @(negedge clk);
      found = out_valid && out_eof;
    end
    check("eof_within_2", 64'(found), 64'd1);
    drain("drain_eof_empty");
    // frame of 3 with frame_done during a stalled first EMIT
    step;
    out_ready = 0;
    push(4'd0, 16'd1, 16'd2, 16'd2, 16'd1, 1);
    push(4'd4, 16'd10, 16'd10, 16'd24, 16'd24, 1);
    push(4'd6, 16'd2, 16'd3, 16'd11, 16'd7, 1);
    push_eof(CNT3);
    wait_valid("frame_valid");
    step;
    frame_done = 1;
    step;
    frame_done = 0;
    out_ready = 1;
    drain("drain_frame1");
    // second frame, frame_done together with a queued entry
    step;
    push(4'd0, 16'd5, 16'd6, 16'd6, 16'd5, 1);
    push_eof(CNT1);
    frame_done = 1;
    step;
    frame_done = 0;
    drain("drain_frame2");
    // latency from rq_re to out_valid
    step;
    push(4'd0, 16'd20, 16'd10, 16'd10, 16'd20, 1);
    for (int i = 0; i < 20 && !rq_re; i++) @(negedge clk);
    check("rq_re_seen", 64'(rq_re), 64'd1);
    t0 = cyc;
    wait_valid("lat_valid");
    check("latency", 64'(cyc - t0), 64'd3);
    drain("drain_basic");
    // scaling values, out-of-range scale index and saturation
    step;
    push(4'd2, 16'd7, 16'd100, 16'd156, 16'd10, 1);
    push(4'd15, 16'd300, 16'd1234, 16'd1234, 16'd300, 1);
    push(4'd7, 16'd65535, 16'd60000, 16'hFFFF, 16'hFFFF, 1);
    push(4'd7, 16'd13000, 16'd1000, 16'd4769, 16'd62003, 1);
    push(4'd5, 16'd3, 16'd50, 16'd152, 16'd9, 1);
    drain("drain_values");
    // backpressure: record held, no pops while stalled
    step;
    out_ready = 0;
    push(4'd1, 16'd8, 16'd16, 16'd20, 16'd10, 1);
    push(4'd3, 16'd4, 16'd512, 16'd1000, 16'd7, 1);
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold_valid", 64'(out_valid), 64'd1);
      check("stall_hold_x", 64'(out_x), 64'd20);
      check("stall_no_pop", 64'(rq_re), 64'd0);
    end
    step;
    out_ready = 1;
    drain("drain_stall");
    // reset during EMIT drops the captured entry; the next one proceeds
    step;
    out_ready = 0;
    push(4'd1, 16'd1, 16'd1, 16'd0, 16'd0, 0);
    push(4'd0, 16'd9, 16'd8, 16'd8, 16'd9, 1);
    wait_valid("rst_pre_valid");
    reset = 1;
    #1;
    check("rst_valid_drop", 64'(out_valid), 64'd0);
    step;
    reset = 0;
    out_ready = 1;
    drain("drain_after_reset");
    repeat (20) step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
